// File: rtl/branch_resolve_unit_if.sv
// Bus between the EX stage, fetch redirect logic and the branch predictor
// update port of branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_op1;
    logic [6:0]       in_opcode;
    logic [2:0]       in_func3;
    logic             zero_flag;
    logic             lt_flag;
    logic             ltu_flag;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;

    logic             upd_valid;
    logic             upd_ready;
    logic [XLEN-1:0]  upd_pc;
    logic [XLEN-1:0]  upd_target;
    logic             upd_taken;
    logic             upd_is_jump;

    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport slave (
        input  in_valid, in_pc, in_imm, in_op1, in_opcode, in_func3,
               zero_flag, lt_flag, ltu_flag, pred_taken, pred_target, upd_ready,
        output in_ready, redirect_valid, redirect_pc, flush,
               upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
               branch_cnt, mispredict_cnt
    );

    modport master (
        output in_valid, in_pc, in_imm, in_op1, in_opcode, in_func3,
               zero_flag, lt_flag, ltu_flag, pred_taken, pred_target, upd_ready,
        input  in_ready, redirect_valid, redirect_pc, flush,
               upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
               branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: checks fetch predictions, issues a registered
// redirect on mispredict and queues predictor-training records.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam int         PTR_W    = $clog2(UPD_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            is_jump;
    } upd_rec_t;

    logic            is_jal, is_jalr, is_btype, is_ctrl;
    logic            cond, actual_taken, mispredict;
    logic            accept, push, pop, full, empty;
    logic [XLEN-1:0] jalr_sum, target, fallthrough;

    logic [PTR_W:0]  wr_ptr, rd_ptr;
    upd_rec_t        fifo_mem [UPD_DEPTH];
    upd_rec_t        head;

    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

    assign is_jal   = (bus.in_opcode == OP_JAL);
    assign is_jalr  = (bus.in_opcode == OP_JALR);
    assign is_btype = (bus.in_opcode == OP_BTYPE);
    assign is_ctrl  = is_jal | is_jalr | is_btype;

    always_comb begin
        cond = 1'b0;
        case (bus.in_func3)
            3'b000:  cond = bus.zero_flag;
            3'b001:  cond = ~bus.zero_flag;
            3'b100:  cond = bus.lt_flag;
            3'b101:  cond = ~bus.lt_flag;
            3'b110:  cond = bus.ltu_flag;
            3'b111:  cond = ~bus.ltu_flag;
            default: cond = 1'b0;
        endcase
    end

    // JALR clears bit 0 of the computed address; all sums wrap modulo 2^XLEN
    assign jalr_sum     = bus.in_op1 + bus.in_imm;
    assign target       = is_jalr ? (jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1})
                                  : (bus.in_pc + bus.in_imm);
    assign fallthrough  = bus.in_pc + XLEN'(4);
    assign actual_taken = is_jal | is_jalr | (is_btype & cond);
    assign mispredict   = (actual_taken != bus.pred_taken) |
                          (actual_taken & bus.pred_taken & (bus.pred_target != target));

    assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    // An instruction arriving while a redirect is out is on the wrong path
    assign accept = bus.in_valid & ~full & ~redirect_valid_q;
    assign push   = accept & is_ctrl;
    assign pop    = ~empty & bus.upd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= accept & mispredict;
            if (accept & mispredict)
                redirect_pc_q <= actual_taken ? target : fallthrough;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{pc: bus.in_pc, target: target,
                                            taken: actual_taken, is_jump: is_jal | is_jalr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (push && branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (accept && mispredict && mispredict_cnt_q != '1)
                mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
        end
    end

    // Head fields read as zero while the queue is empty
    assign head = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign bus.in_ready       = ~full;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = redirect_valid_q;
    assign bus.upd_valid      = ~empty;
    assign bus.upd_pc         = empty ? '0 : head.pc;
    assign bus.upd_target     = empty ? '0 : head.target;
    assign bus.upd_taken      = empty ? 1'b0 : head.taken;
    assign bus.upd_is_jump    = empty ? 1'b0 : head.is_jump;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected update records are queued
// at issue time and compared as the predictor port drains them.
module tb_branch_resolve_unit;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_jump;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_br = 0;
    int   exp_mis = 0;
    rec_t sb_q[$];

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .UPD_DEPTH(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Update-port monitor: the head must match the scoreboard whenever valid
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.upd_valid === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("[TB] FAIL upd_unexpected: got record pc=%h tgt=%h, required none",
                         bus.upd_pc, bus.upd_target);
            end else begin
                if ({bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_is_jump} !==
                    {sb_q[0].pc, sb_q[0].target, sb_q[0].taken, sb_q[0].is_jump}) begin
                    n_err++;
                    $display("[TB] FAIL upd_record: got %h/%h/%b/%b required %h/%h/%b/%b",
                             bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_is_jump,
                             sb_q[0].pc, sb_q[0].target, sb_q[0].taken, sb_q[0].is_jump);
                end
                if (bus.upd_ready === 1'b1) void'(sb_q.pop_front());
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] op1,
                         input logic z, input logic lt, input logic ltu,
                         input logic pt, input logic [31:0] ptgt);
        bus.in_valid    = 1'b1;
        bus.in_opcode   = op;
        bus.in_func3    = f3;
        bus.in_pc       = pc;
        bus.in_imm      = imm;
        bus.in_op1      = op1;
        bus.zero_flag   = z;
        bus.lt_flag     = lt;
        bus.ltu_flag    = ltu;
        bus.pred_taken  = pt;
        bus.pred_target = ptgt;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic jmp);
        rec_t r;
        r.pc = pc; r.target = tgt; r.taken = tk; r.is_jump = jmp;
        sb_q.push_back(r);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.upd_ready = 1'b1;
        drive(OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.in_valid = 1'b0;
        step; step;
        rst_n = 1'b1;
        step;
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_redirect_valid: got %b required 0", bus.redirect_valid); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_err++; $display("[TB] FAIL rst_flush: got %b required 0", bus.flush); end
        n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_err++; $display("[TB] FAIL rst_redirect_pc: got %h required 0", bus.redirect_pc); end
        n_cmp++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_upd_valid: got %b required 0", bus.upd_valid); end
        n_cmp++; if (bus.upd_pc !== 32'h0) begin n_err++; $display("[TB] FAIL rst_upd_pc: got %h required 0", bus.upd_pc); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_in_ready: got %b required 1", bus.in_ready); end
        n_cmp++; if (bus.branch_cnt !== 32'd0) begin n_err++; $display("[TB] FAIL rst_branch_cnt: got %0d required 0", bus.branch_cnt); end
        n_cmp++; if (bus.mispredict_cnt !== 32'd0) begin n_err++; $display("[TB] FAIL rst_mispredict_cnt: got %0d required 0", bus.mispredict_cnt); end
    endtask

    task automatic test_beq_taken;
        drive(OP_BTYPE, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_exp(32'h100, 32'h120, 1'b1, 1'b0);
        exp_br++; exp_mis++;
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("[TB] FAIL beq_redirect_valid: got %b required 1", bus.redirect_valid); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_err++; $display("[TB] FAIL beq_flush: got %b required 1", bus.flush); end
        n_cmp++; if (bus.redirect_pc !== 32'h120) begin n_err++; $display("[TB] FAIL beq_redirect_pc: got %h required 120", bus.redirect_pc); end
        n_cmp++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin n_err++; $display("[TB] FAIL beq_mispredict_cnt: got %0d required %0d", bus.mispredict_cnt, exp_mis); end
        n_cmp++; if (bus.branch_cnt !== 32'(exp_br)) begin n_err++; $display("[TB] FAIL beq_branch_cnt: got %0d required %0d", bus.branch_cnt, exp_br); end
        step;
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("[TB] FAIL beq_pulse_end: got %b required 0", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h120) begin n_err++; $display("[TB] FAIL beq_pc_hold: got %h required 120", bus.redirect_pc); end
    endtask

    task automatic test_jalr;
        drive(OP_JALR, 3'b000, 32'h3000, 32'h4, 32'h2003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2006);
        push_exp(32'h3000, 32'h2006, 1'b1, 1'b1);
        exp_br++;
        step;
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("[TB] FAIL jalr_hit_redirect: got %b required 0", bus.redirect_valid); end
        n_cmp++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin n_err++; $display("[TB] FAIL jalr_hit_mis_cnt: got %0d required %0d", bus.mispredict_cnt, exp_mis); end
        drive(OP_JALR, 3'b000, 32'h3004, 32'h4, 32'h2003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000);
        push_exp(32'h3004, 32'h2006, 1'b1, 1'b1);
        exp_br++; exp_mis++;
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("[TB] FAIL jalr_tgt_redirect: got %b required 1", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h2006) begin n_err++; $display("[TB] FAIL jalr_tgt_pc: got %h required 2006", bus.redirect_pc); end
        n_cmp++; if (bus.branch_cnt !== 32'(exp_br)) begin n_err++; $display("[TB] FAIL jalr_branch_cnt: got %0d required %0d", bus.branch_cnt, exp_br); end
        step;
    endtask

    task automatic test_wrap;
        drive(OP_BTYPE, 3'b001, 32'hFFFF_FFFC, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_000C);
        push_exp(32'hFFFF_FFFC, 32'h0000_000C, 1'b0, 1'b0);
        exp_br++; exp_mis++;
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_redirect: got %b required 1", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_err++; $display("[TB] FAIL wrap_pc: got %h required 00000000", bus.redirect_pc); end
        step;
    endtask

    task automatic test_non_ctrl;
        drive(OP_ALU, 3'b000, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h600);
        exp_mis++;
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("[TB] FAIL nonctrl_redirect: got %b required 1", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h504) begin n_err++; $display("[TB] FAIL nonctrl_pc: got %h required 504", bus.redirect_pc); end
        n_cmp++; if (bus.branch_cnt !== 32'(exp_br)) begin n_err++; $display("[TB] FAIL nonctrl_branch_cnt: got %0d required %0d", bus.branch_cnt, exp_br); end
        n_cmp++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin n_err++; $display("[TB] FAIL nonctrl_mis_cnt: got %0d required %0d", bus.mispredict_cnt, exp_mis); end
        step;
    endtask

    task automatic test_wrong_path;
        drive(OP_BTYPE, 3'b000, 32'h700, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h800);
        push_exp(32'h700, 32'h800, 1'b0, 1'b0);
        exp_br++; exp_mis++;
        step;
        n_cmp++; if (bus.redirect_pc !== 32'h704) begin n_err++; $display("[TB] FAIL wp_first_pc: got %h required 704", bus.redirect_pc); end
        drive(OP_JAL, 3'b000, 32'h900, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("[TB] FAIL wp_ignored_redirect: got %b required 0", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h704) begin n_err++; $display("[TB] FAIL wp_pc_hold: got %h required 704", bus.redirect_pc); end
        n_cmp++; if (bus.branch_cnt !== 32'(exp_br)) begin n_err++; $display("[TB] FAIL wp_branch_cnt: got %0d required %0d", bus.branch_cnt, exp_br); end
        n_cmp++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin n_err++; $display("[TB] FAIL wp_mis_cnt: got %0d required %0d", bus.mispredict_cnt, exp_mis); end
        step;
    endtask

    task automatic test_full;
        logic [31:0] pc;
        bus.upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h1000 + 32'(i * 16);
            drive(OP_BTYPE, 3'b100, pc, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, pc + 32'h40);
            push_exp(pc, pc + 32'h40, 1'b1, 1'b0);
            exp_br++;
            step;
            n_cmp++;
            if (bus.in_ready !== (i < 3 ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("[TB] FAIL full_in_ready_%0d: got %b required %b", i, bus.in_ready, (i < 3 ? 1'b1 : 1'b0));
            end
        end
        drive(OP_BTYPE, 3'b100, 32'h2000, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2040);
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.branch_cnt !== 32'(exp_br)) begin n_err++; $display("[TB] FAIL full_blocked_cnt: got %0d required %0d", bus.branch_cnt, exp_br); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_still_full: got %b required 0", bus.in_ready); end
        bus.upd_ready = 1'b1;
        step;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL full_ready_return: got %b required 1", bus.in_ready); end
        for (int k = 0; k < 10; k++) begin
            if (bus.upd_valid !== 1'b1) break;
            step;
        end
        n_cmp++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("[TB] FAIL full_drain: got upd_valid %b required 0", bus.upd_valid); end
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("[TB] FAIL full_drain_sb: got %0d pending required 0", sb_q.size()); end
    endtask

    task automatic test_random;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc, imm, op1, op2, tgt, ptgt, good_pc;
        logic        tk, pt, ctrl, mis;
        bus.upd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_JAL;
                1:       op = OP_JALR;
                2:       op = OP_BTYPE;
                default: op = OP_ALU;
            endcase
            f3  = 3'($urandom_range(0, 7));
            pc  = $urandom;
            imm = $urandom;
            op1 = $urandom;
            op2 = ($urandom_range(0, 3) == 0) ? op1 : $urandom;
            ctrl = (op != OP_ALU);
            tgt = pc + imm;
            tk  = 1'b0;
            if (op == OP_JAL) tk = 1'b1;
            if (op == OP_JALR) begin tk = 1'b1; tgt = (op1 + imm) & 32'hFFFF_FFFE; end
            if (op == OP_BTYPE) begin
                if (f3 == 3'd0) tk = (op1 == op2);
                if (f3 == 3'd1) tk = (op1 != op2);
                if (f3 == 3'd4) tk = ($signed(op1) < $signed(op2));
                if (f3 == 3'd5) tk = ($signed(op1) >= $signed(op2));
                if (f3 == 3'd6) tk = (op1 < op2);
                if (f3 == 3'd7) tk = (op1 >= op2);
            end
            pt   = 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
            mis  = (tk != pt) || (tk && pt && ptgt != tgt);
            good_pc = tk ? tgt : pc + 32'd4;
            drive(op, f3, pc, imm, op1, op1 == op2, $signed(op1) < $signed(op2), op1 < op2, pt, ptgt);
            if (ctrl) begin push_exp(pc, tgt, tk, (op == OP_JAL) || (op == OP_JALR)); exp_br++; end
            if (mis) exp_mis++;
            step;
            bus.in_valid = 1'b0;
            n_cmp++; if (bus.redirect_valid !== mis) begin n_err++; $display("[TB] FAIL rnd%0d_redirect: got %b required %b", n, bus.redirect_valid, mis); end
            if (mis) begin
                n_cmp++; if (bus.redirect_pc !== good_pc) begin n_err++; $display("[TB] FAIL rnd%0d_pc: got %h required %h", n, bus.redirect_pc, good_pc); end
            end
            n_cmp++; if (bus.branch_cnt !== 32'(exp_br)) begin n_err++; $display("[TB] FAIL rnd%0d_branch_cnt: got %0d required %0d", n, bus.branch_cnt, exp_br); end
            n_cmp++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin n_err++; $display("[TB] FAIL rnd%0d_mis_cnt: got %0d required %0d", n, bus.mispredict_cnt, exp_mis); end
            if (mis) step;
        end
        step; step;
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("[TB] FAIL rnd_sb_empty: got %0d pending required 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid;
        bus.upd_ready = 1'b0;
        drive(OP_JAL, 3'b000, 32'h4000, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4080);
        push_exp(32'h4000, 32'h4080, 1'b1, 1'b1);
        step;
        drive(OP_JAL, 3'b000, 32'h4080, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4100);
        push_exp(32'h4080, 32'h4100, 1'b1, 1'b1);
        step;
        drive(OP_JAL, 3'b000, 32'h4100, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        push_exp(32'h4100, 32'h4180, 1'b1, 1'b1);
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mid_pending_redirect: got %b required 1", bus.redirect_valid); end
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        exp_br = 0; exp_mis = 0;
        #1;
        n_cmp++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_upd_valid: got %b required 0", bus.upd_valid); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_redirect_valid: got %b required 0", bus.redirect_valid); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_err++; $display("[TB] FAIL mid_flush: got %b required 0", bus.flush); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL mid_in_ready: got %b required 1", bus.in_ready); end
        n_cmp++; if (bus.branch_cnt !== 32'd0) begin n_err++; $display("[TB] FAIL mid_branch_cnt: got %0d required 0", bus.branch_cnt); end
        n_cmp++; if (bus.mispredict_cnt !== 32'd0) begin n_err++; $display("[TB] FAIL mid_mis_cnt: got %0d required 0", bus.mispredict_cnt); end
        step;
        rst_n = 1'b1;
        bus.upd_ready = 1'b1;
        step;
        n_cmp++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_after_release: got upd_valid %b required 0", bus.upd_valid); end
    endtask

    initial begin
        $display("[TB] branch_resolve_unit bench starting");
        test_reset;
        test_beq_taken;
        test_jalr;
        test_wrap;
        test_non_ctrl;
        test_wrong_path;
        test_full;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
